// File: rtl/soc_node_err_slv.sv
// ---------------------------------------------------------------------------
// soc_node_err_slv
//
// AXI4 error responder for an unmapped or decoupled master port of the SoC
// AXI node. Every transaction it receives is terminated with a fixed error
// response, so the interconnect never stalls. It follows full burst
// semantics: all W beats are sunk, one B is returned per write, and exactly
// len+1 R beats are returned per read. Saturating error counters and a
// last-error address register are exposed for debug.
//
// Only the AXI fields that influence the response are brought out as ports.
// Write data/strobes, burst type/size, cache/prot/qos/region/user and aw_len
// have no effect on the error response and are left unconnected at the node.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   aw_*                   write address channel (valid/ready/addr/id)
//   w_*                    write data channel (valid/ready/last)
//   b_*                    write response channel
//   ar_*                   read address channel (valid/ready/addr/id/len)
//   r_*                    read data channel
//   clear_i                synchronous clear of counters and err_addr_o
//   wr_err_cnt_o           completed error writes, saturating at 16'hFFFF
//   rd_err_cnt_o           completed error reads, saturating at 16'hFFFF
//   err_addr_o             address of the most recently accepted request
//
// State table
//   W_IDLE | waiting for AW; aw_ready high
//   W_DATA | sinking W beats until w_last; w_ready high
//   W_RESP | presenting B until b_ready
//   R_IDLE | waiting for AR; ar_ready high
//   R_DATA | presenting R beats until the beat with r_last is accepted
// ---------------------------------------------------------------------------
module soc_node_err_slv #(
    parameter int unsigned AXI_AW = 32,
    parameter int unsigned AXI_DW = 64,
    parameter int unsigned AXI_IW = 8,
    parameter int unsigned AXI_UW = 6,
    parameter logic [1:0]  RESP   = 2'b11,
    parameter logic [63:0] RDATA  = 64'hBADC_AB1E_BADC_AB1E
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [AXI_AW-1:0] aw_addr,
    input  logic [AXI_IW-1:0] aw_id,

    input  logic              w_valid,
    output logic              w_ready,
    input  logic              w_last,

    output logic              b_valid,
    input  logic              b_ready,
    output logic [AXI_IW-1:0] b_id,
    output logic [1:0]        b_resp,
    output logic [AXI_UW-1:0] b_user,

    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [AXI_AW-1:0] ar_addr,
    input  logic [AXI_IW-1:0] ar_id,
    input  logic [7:0]        ar_len,

    output logic              r_valid,
    input  logic              r_ready,
    output logic [AXI_IW-1:0] r_id,
    output logic [AXI_DW-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic [AXI_UW-1:0] r_user,

    input  logic              clear_i,
    output logic [15:0]       wr_err_cnt_o,
    output logic [15:0]       rd_err_cnt_o,
    output logic [AXI_AW-1:0] err_addr_o
);

    localparam logic [AXI_DW-1:0] RDATA_W = AXI_DW'(RDATA);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;

    logic              aw_ready_q;
    logic              ar_ready_q;
    logic [AXI_IW-1:0] w_id_q;
    logic [AXI_IW-1:0] r_id_q;
    logic [7:0]        r_len_q;
    logic [7:0]        r_cnt_q;
    logic [15:0]       wr_cnt_q;
    logic [15:0]       rd_cnt_q;
    logic [AXI_AW-1:0] err_addr_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = aw_valid & aw_ready_q;
    assign w_hs  = w_valid  & w_ready;
    assign b_hs  = b_valid  & b_ready;
    assign ar_hs = ar_valid & ar_ready_q;
    assign r_hs  = r_valid  & r_ready;

    // -----------------------------------------------------------------------
    // State registers. The address readies are registered from the next
    // state so that both stay low in reset and rise on the first edge after.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_ready_q <= 1'b0;
            ar_ready_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_ready_q <= (w_state_d == W_IDLE);
            ar_ready_q <= (r_state_d == R_IDLE);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_hs)          w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last) w_state_d = W_RESP;
            W_RESP:  if (b_hs)           w_state_d = W_IDLE;
            default:                     w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        if (r_state_q == R_IDLE) begin
            if (ar_hs) r_state_d = R_DATA;
        end else begin
            if (r_hs && r_last) r_state_d = R_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        aw_ready = aw_ready_q;
        ar_ready = ar_ready_q;
        w_ready  = (w_state_q == W_DATA);
        b_valid  = (w_state_q == W_RESP);
        r_valid  = (r_state_q == R_DATA);
        r_last   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
        b_id     = w_id_q;
        b_resp   = RESP;
        b_user   = '0;
        r_id     = r_id_q;
        r_data   = RDATA_W;
        r_resp   = RESP;
        r_user   = '0;
    end

    // -----------------------------------------------------------------------
    // Captured request fields and beat counter. The counter stops on the
    // last beat so len=255 never wraps while r_last is being presented.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_id_q  <= '0;
            r_id_q  <= '0;
            r_len_q <= '0;
            r_cnt_q <= '0;
        end else begin
            if (aw_hs) w_id_q <= aw_id;
            if (ar_hs) begin
                r_id_q  <= ar_id;
                r_len_q <= ar_len;
                r_cnt_q <= '0;
            end else if (r_hs && !r_last) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Debug counters and last-error address. Clear wins over everything;
    // a write address wins over a read address in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_addr_q <= '0;
        end else if (clear_i) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_addr_q <= '0;
        end else begin
            if (b_hs && (wr_cnt_q != 16'hFFFF))
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (r_hs && r_last && (rd_cnt_q != 16'hFFFF))
                rd_cnt_q <= rd_cnt_q + 16'd1;
            if (aw_hs)
                err_addr_q <= aw_addr;
            else if (ar_hs)
                err_addr_q <= ar_addr;
        end
    end

    assign wr_err_cnt_o = wr_cnt_q;
    assign rd_err_cnt_o = rd_cnt_q;
    assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_soc_node_err_slv.sv
module tb_soc_node_err_slv;

    localparam int TMO = 4000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_id;
    logic        w_valid, w_ready, w_last;
    logic        b_valid, b_ready;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic [5:0]  b_user;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_id;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [7:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [5:0]  r_user;
    logic        clear_i;
    logic [15:0] wr_err_cnt_o, rd_err_cnt_o;
    logic [31:0] err_addr_o;

    soc_node_err_slv dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .aw_valid     (aw_valid),
        .aw_ready     (aw_ready),
        .aw_addr      (aw_addr),
        .aw_id        (aw_id),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_last       (w_last),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_id         (b_id),
        .b_resp       (b_resp),
        .b_user       (b_user),
        .ar_valid     (ar_valid),
        .ar_ready     (ar_ready),
        .ar_addr      (ar_addr),
        .ar_id        (ar_id),
        .ar_len       (ar_len),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_id         (r_id),
        .r_data       (r_data),
        .r_resp       (r_resp),
        .r_last       (r_last),
        .r_user       (r_user),
        .clear_i      (clear_i),
        .wr_err_cnt_o (wr_err_cnt_o),
        .rd_err_cnt_o (rd_err_cnt_o),
        .err_addr_o   (err_addr_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within %0d cycles", nm, TMO);
    endtask

    // Reference model: transaction-level view of what the responder owes.
    typedef struct { logic [7:0] id; logic last; } rbeat_t;
    rbeat_t      r_q[$];
    logic [7:0]  b_q[$];
    int          wr_stage = 0;     // 0 no write, 1 owes W acceptance, 2 owes B
    bit          rd_busy  = 0;
    logic [15:0] m_wr = '0;
    logic [15:0] m_rd = '0;
    logic [31:0] m_addr = '0;
    logic        edges = 1'b0;     // at least one clock edge since reset release
    logic [63:0] exp_rdata;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) edges <= 1'b0;
        else         edges <= 1'b1;
    end

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        bit is_last;
        exp_rdata = 64'hBADC_AB1E_BADC_AB1E;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_aw_ready", 64'(aw_ready), 64'(0));
                chk("rst_ar_ready", 64'(ar_ready), 64'(0));
                chk("rst_w_ready",  64'(w_ready),  64'(0));
                chk("rst_b_valid",  64'(b_valid),  64'(0));
                chk("rst_r_valid",  64'(r_valid),  64'(0));
                chk("rst_r_last",   64'(r_last),   64'(0));
                chk("rst_b_id",     64'(b_id),     64'(0));
                chk("rst_r_id",     64'(r_id),     64'(0));
                chk("rst_wr_cnt",   64'(wr_err_cnt_o), 64'(0));
                chk("rst_rd_cnt",   64'(rd_err_cnt_o), 64'(0));
                chk("rst_err_addr", 64'(err_addr_o),   64'(0));
                r_q.delete();
                b_q.delete();
                wr_stage = 0;
                rd_busy  = 0;
                m_wr = '0; m_rd = '0; m_addr = '0;
            end else begin
                chk("aw_ready", 64'(aw_ready), 64'(edges && wr_stage == 0));
                chk("w_ready",  64'(w_ready),  64'(wr_stage == 1));
                chk("b_valid",  64'(b_valid),  64'(wr_stage == 2));
                chk("ar_ready", 64'(ar_ready), 64'(edges && !rd_busy));
                chk("r_valid",  64'(r_valid),  64'(rd_busy));
                chk("wr_cnt",   64'(wr_err_cnt_o), 64'(m_wr));
                chk("rd_cnt",   64'(rd_err_cnt_o), 64'(m_rd));
                chk("err_addr", 64'(err_addr_o),   64'(m_addr));
                if (b_valid && b_q.size() > 0) begin
                    chk("b_id",   64'(b_id),   64'(b_q[0]));
                    chk("b_resp", 64'(b_resp), 64'(2'b11));
                    chk("b_user", 64'(b_user), 64'(0));
                end
                if (r_valid && r_q.size() > 0) begin
                    chk("r_id",   64'(r_id),   64'(r_q[0].id));
                    chk("r_data", r_data,      exp_rdata);
                    chk("r_resp", 64'(r_resp), 64'(2'b11));
                    chk("r_last", 64'(r_last), 64'(r_q[0].last));
                    chk("r_user", 64'(r_user), 64'(0));
                end
                // Events that the next rising edge will commit.
                if (aw_valid && aw_ready) begin
                    b_q.push_back(aw_id);
                    wr_stage = 1;
                    m_addr = aw_addr;
                end else if (ar_valid && ar_ready) begin
                    m_addr = ar_addr;
                end
                if (ar_valid && ar_ready) begin
                    for (int i = 0; i <= int'(ar_len); i++)
                        r_q.push_back('{id: ar_id, last: (i == int'(ar_len))});
                    rd_busy = 1;
                end
                if (w_valid && w_ready && w_last) wr_stage = 2;
                if (b_valid && b_ready) begin
                    if (b_q.size() > 0) void'(b_q.pop_front());
                    wr_stage = 0;
                    if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
                end
                if (r_valid && r_ready) begin
                    is_last = (r_q.size() > 0) ? r_q[0].last : 1'b1;
                    if (r_q.size() > 0) void'(r_q.pop_front());
                    if (is_last) begin
                        rd_busy = 0;
                        if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
                    end
                end
                if (clear_i) begin
                    m_wr = '0; m_rd = '0; m_addr = '0;
                end
            end
        end
    end

    task automatic wr_txn(input logic [7:0] id, input logic [31:0] addr, input int n,
                          input bit bp, input bit clr_b);
        int t;
        bit done;
        @(posedge clk_i); #1;
        aw_valid = 1'b1; aw_id = id; aw_addr = addr;
        if (bp && $urandom_range(0, 1) == 1) begin
            w_valid = 1'b1; w_last = (n == 1);
        end
        done = 0; t = 0;
        while (!done && t < TMO) begin
            @(negedge clk_i); done = aw_ready; @(posedge clk_i); #1; t++;
        end
        aw_valid = 1'b0;
        if (!done) fail_tmo("aw");
        for (int i = 0; i < n; i++) begin
            if (bp && $urandom_range(0, 3) == 0) begin
                w_valid = 1'b0; @(posedge clk_i); #1;
            end
            w_valid = 1'b1; w_last = (i == n - 1);
            done = 0; t = 0;
            while (!done && t < TMO) begin
                @(negedge clk_i); done = w_ready; @(posedge clk_i); #1; t++;
            end
            if (!done) fail_tmo("w");
        end
        w_valid = 1'b0; w_last = 1'b0;
        if (clr_b) begin
            done = 0; t = 0;
            while (!done && t < TMO) begin
                @(negedge clk_i); done = b_valid; @(posedge clk_i); #1; t++;
            end
            if (!done) fail_tmo("b_clr");
            b_ready = 1'b1; clear_i = 1'b1;
            @(posedge clk_i); #1;
            b_ready = 1'b0; clear_i = 1'b0;
        end else begin
            done = 0; t = 0;
            while (!done && t < TMO) begin
                b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk_i); done = b_valid && b_ready; @(posedge clk_i); #1; t++;
            end
            b_ready = 1'b0;
            if (!done) fail_tmo("b");
        end
    endtask

    task automatic rd_txn(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input bit bp, output int beats);
        int t;
        bit done;
        beats = 0;
        @(posedge clk_i); #1;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
        done = 0; t = 0;
        while (!done && t < TMO) begin
            @(negedge clk_i); done = ar_ready; @(posedge clk_i); #1; t++;
        end
        ar_valid = 1'b0;
        if (!done) fail_tmo("ar");
        done = 0; t = 0;
        while (!done && t < TMO) begin
            r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            if (r_valid && r_ready) begin
                beats++;
                done = r_last;
            end
            @(posedge clk_i); #1; t++;
        end
        r_ready = 1'b0;
        if (!done) fail_tmo("r");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, rb2, t;
        bit done;
        logic [7:0] rl;
        rst_ni = 1'b0;
        aw_valid = 0; aw_addr = '0; aw_id = '0;
        w_valid = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0;
        r_ready = 0; clear_i = 0;
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_exit_aw_ready_low", 64'(aw_ready), 64'(0));
        @(negedge clk_i);
        chk("rst_exit_aw_ready_high", 64'(aw_ready), 64'(1));
        chk("rst_exit_ar_ready_high", 64'(ar_ready), 64'(1));

        // Single read
        rd_txn(8'h05, 32'hDEAD_0040, 8'd0, 0, rb);
        chk("single_rd_beats", 64'(rb), 64'(1));
        chk("single_rd_cnt", 64'(rd_err_cnt_o), 64'(1));
        chk("single_rd_addr", 64'(err_addr_o), 64'h0000_0000_DEAD_0040);

        // Write burst of 4 beats
        wr_txn(8'h03, 32'h0000_0800, 4, 0, 0);
        chk("burst_wr_cnt", 64'(wr_err_cnt_o), 64'(1));

        // Simultaneous AW and AR
        fork
            wr_txn(8'h01, 32'h0000_1000, 1, 0, 0);
            rd_txn(8'h02, 32'h0000_2000, 8'd0, 0, rb);
        join
        chk("simul_addr", 64'(err_addr_o), 64'h1000);
        chk("simul_wr_cnt", 64'(wr_err_cnt_o), 64'(2));
        chk("simul_rd_cnt", 64'(rd_err_cnt_o), 64'(2));

        // len=255 with random backpressure
        rd_txn(8'h07, 32'h0000_3000, 8'd255, 1, rb);
        chk("len255_beats", 64'(rb), 64'(256));

        // Random concurrent traffic
        for (int k = 0; k < 25; k++) begin
            rl = 8'($urandom_range(0, 15));
            fork
                wr_txn(8'($urandom), $urandom, $urandom_range(1, 8), 1'($urandom_range(0, 1)), 0);
                rd_txn(8'($urandom), $urandom, rl, 1'($urandom_range(0, 1)), rb2);
            join
            chk("rand_rd_beats", 64'(rb2), 64'(int'(rl) + 1));
        end

        // Saturation then clear on a B handshake
        @(posedge clk_i); #2;
        force dut.wr_cnt_q = 16'hFFFF;
        m_wr = 16'hFFFF;
        #1;
        release dut.wr_cnt_q;
        wr_txn(8'h11, 32'h0000_6000, 2, 0, 0);
        chk("sat_wr_cnt", 64'(wr_err_cnt_o), 64'hFFFF);
        wr_txn(8'h12, 32'h0000_7000, 1, 0, 1);
        chk("clear_wr_cnt", 64'(wr_err_cnt_o), 64'(0));
        chk("clear_rd_cnt", 64'(rd_err_cnt_o), 64'(0));
        chk("clear_addr", 64'(err_addr_o), 64'(0));

        // Reset in the middle of a len=7 read
        @(posedge clk_i); #1;
        ar_valid = 1'b1; ar_id = 8'h0A; ar_len = 8'd7; ar_addr = 32'h0000_4000; r_ready = 1'b1;
        done = 0; t = 0;
        while (!done && t < TMO) begin
            @(negedge clk_i); done = ar_ready; @(posedge clk_i); #1; t++;
        end
        ar_valid = 1'b0;
        if (!done) fail_tmo("ar_rst");
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk("rst_mid_r_valid", 64'(r_valid), 64'(0));
        chk("rst_mid_ar_ready", 64'(ar_ready), 64'(0));
        r_ready = 1'b0;
        @(posedge clk_i); #2 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_exit_ar_low", 64'(ar_ready), 64'(0));
        @(negedge clk_i);
        chk("rst_mid_exit_ar_high", 64'(ar_ready), 64'(1));
        rd_txn(8'h0B, 32'h0000_5000, 8'd3, 0, rb);
        chk("post_rst_beats", 64'(rb), 64'(4));
        chk("post_rst_rd_cnt", 64'(rd_err_cnt_o), 64'(1));
        chk("post_rst_addr", 64'(err_addr_o), 64'h5000);

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
